// File: rtl/key_pkg.sv
// key_pkg
// Shared types and helpers for the push-button front end.
//   key_state_e : per-channel debounce state, gray encoded so that every
//                 legal transition flips a single bit (matches the control FSM).
//   cnt_width() : width of the debounce counter for a given cycle count.
package key_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'b00,
        PRESS_WAIT   = 2'b01,
        HELD         = 2'b11,
        RELEASE_WAIT = 2'b10
    } key_state_e;

    // One spare bit above $clog2 so the terminal value always fits.
    function automatic int cnt_width(input int cycles);
        return $clog2(cycles) + 1;
    endfunction

endpackage

// File: rtl/key_pulse_generator_if.sv
// key_pulse_generator_if
// Button bus between the board pins / bench and the pulse generator.
//   key_raw  : raw button levels, asynchronous to clk
//   keys     : one-cycle press pulses, zero or one-hot
//   key_held : debounced pressed level per button
// master drives the raw levels, slave (the generator) drives the results.
interface key_pulse_generator_if #(
    parameter int NUM_KEYS = 4
);
    logic [NUM_KEYS-1:0] key_raw;
    logic [NUM_KEYS-1:0] keys;
    logic [NUM_KEYS-1:0] key_held;

    modport master (output key_raw, input keys, input key_held);
    modport slave  (input key_raw, output keys, output key_held);
endinterface

// File: rtl/key_debounce.sv
// key_debounce
// One button channel: two-flop synchroniser, polarity normalisation,
// debounce counter and press/release state machine.
//   clk, reset  : system clock, asynchronous active-high reset
//   key_raw     : raw button level
//   press_event : registered, high for one cycle when a press is accepted
//   held        : registered debounced pressed level; rises together with
//                 the top-level pulse, falls when release debounce completes
module key_debounce
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic key_raw,
    output logic press_event,
    output logic held
);

    localparam int             CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  TERM     = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic           RELEASED = (ACTIVE_LOW != 0);

    logic [1:0]    sync;
    logic          pressed;
    key_state_e    state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic          event_d;
    logic          release_done;

    // Synchroniser resets to the released level so a button held through
    // reset has to be debounced again from scratch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync <= {2{RELEASED}};
        else       sync <= {sync[0], key_raw};
    end

    assign pressed = sync[1] ^ RELEASED;

    always_comb begin
        state_d      = state;
        cnt_d        = cnt;
        event_d      = 1'b0;
        release_done = 1'b0;
        case (state)
            IDLE: begin
                cnt_d = '0;
                if (pressed) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = CW'(1);
                end
            end
            PRESS_WAIT: begin
                if (!pressed) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt == TERM) begin
                    state_d = HELD;
                    cnt_d   = '0;
                    event_d = 1'b1;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            HELD: begin
                cnt_d = '0;
                if (!pressed) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = CW'(1);
                end
            end
            RELEASE_WAIT: begin
                if (pressed) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt == TERM) begin
                    state_d      = IDLE;
                    cnt_d        = '0;
                    release_done = 1'b1;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // held is set one cycle after the event so it lines up with the
    // registered pulse at the top, but drops on the debounce-complete edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            press_event <= 1'b0;
            held        <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            press_event <= event_d;
            if (press_event)       held <= 1'b1;
            else if (release_done) held <= 1'b0;
        end
    end

endmodule

// File: rtl/key_pulse_generator.sv
// key_pulse_generator
// Turns raw bouncing push-button levels into clean single-cycle press
// pulses for the stopwatch / code-lock control FSM.
//   clk, reset : system clock, asynchronous active-high reset
//   bus.key_raw  (in)  : raw button levels, asynchronous
//   bus.keys     (out) : registered press pulses, zero or one-hot
//   bus.key_held (out) : debounced pressed level per button
// Simultaneous press events resolve to the lowest index (KEY[0] is the
// stopwatch reset and always wins); losers are dropped, not queued.
module key_pulse_generator
    import key_pkg::*;
#(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    key_pulse_generator_if.slave  bus
);

    logic [NUM_KEYS-1:0] press_ev;
    logic [NUM_KEYS-1:0] held;
    logic [NUM_KEYS-1:0] winner;
    logic [NUM_KEYS-1:0] keys_q;

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
        key_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW)
        ) u_ch (
            .clk         (clk),
            .reset       (reset),
            .key_raw     (bus.key_raw[g]),
            .press_event (press_ev[g]),
            .held        (held[g])
        );
    end

    // Isolate the lowest set bit: x & -x.
    assign winner = press_ev & (~press_ev + NUM_KEYS'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) keys_q <= '0;
        else       keys_q <= winner;
    end

    assign bus.keys     = keys_q;
    assign bus.key_held = held;

endmodule

// File: tb/tb_key_pulse_generator.sv
// tb_key_pulse_generator
// Directed stimulus with scoreboard checking. The stimulus process pushes
// expected pulses (cycle, value) and expected key_held samples into queues;
// a monitor process compares at every falling clock edge.
module tb_key_pulse_generator;

    localparam int NK      = 4;
    localparam int DB      = 4;
    localparam int LAT     = DB + 3;   // press pulse / key_held rise
    localparam int REL_LAT = DB + 2;   // key_held fall

    typedef struct {
        int            cyc;
        logic [NK-1:0] val;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;

    exp_t pq[$];
    exp_t hq[$];

    int   tests = 0;
    int   fails = 0;
    logic done  = 1'b0;
    logic final_checked = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    key_pulse_generator_if #(.NUM_KEYS(NK)) kif ();

    key_pulse_generator #(
        .NUM_KEYS        (NK),
        .DEBOUNCE_CYCLES (DB),
        .ACTIVE_LOW      (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (kif.slave)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic exp_pulse(input int dt, input logic [NK-1:0] v);
        pq.push_back('{cyc + dt, v});
    endtask

    task automatic exp_held(input int dt, input logic [NK-1:0] v);
        hq.push_back('{cyc + dt, v});
    endtask

    // Monitor / scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                tests++;
                if (kif.keys !== '0 || kif.key_held !== '0) begin
                    fails++;
                    $display("FAIL reset_clear: keys=%b key_held=%b, required 0000/0000",
                             kif.keys, kif.key_held);
                end
            end else begin
                while (pq.size() > 0 && pq[0].cyc < cyc) begin
                    e = pq.pop_front();
                    tests++;
                    fails++;
                    $display("FAIL pulse_missing: no pulse seen, required keys=%b at cycle %0d",
                             e.val, e.cyc);
                end
                if (kif.keys !== '0) begin
                    tests++;
                    if (pq.size() == 0) begin
                        fails++;
                        $display("FAIL pulse_unexpected: keys=%b at cycle %0d, required 0000",
                                 kif.keys, cyc);
                    end else begin
                        e = pq.pop_front();
                        if (e.cyc != cyc || kif.keys !== e.val) begin
                            fails++;
                            $display("FAIL pulse_check: keys=%b at cycle %0d, required %b at cycle %0d",
                                     kif.keys, cyc, e.val, e.cyc);
                        end
                    end
                end
            end
            while (hq.size() > 0 && hq[0].cyc <= cyc) begin
                e = hq.pop_front();
                tests++;
                if (e.cyc != cyc || kif.key_held !== e.val) begin
                    fails++;
                    $display("FAIL held_check: key_held=%b at cycle %0d, required %b at cycle %0d",
                             kif.key_held, cyc, e.val, e.cyc);
                end
            end
            if (done && !final_checked) begin
                tests++;
                if (pq.size() != 0 || hq.size() != 0) begin
                    fails++;
                    $display("FAIL scoreboard_drain: %0d pulses and %0d held checks pending, required 0/0",
                             pq.size(), hq.size());
                end
                final_checked = 1'b1;
            end
        end
    end

    // Stimulus
    initial begin
        kif.key_raw = '1;
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(3);

        // Clean press on key 1, held 20 cycles
        kif.key_raw[1] = 1'b0;
        exp_pulse(LAT, 4'b0010);
        exp_held(LAT - 1, 4'b0000);
        exp_held(LAT, 4'b0010);
        tick(20);
        kif.key_raw[1] = 1'b1;
        exp_held(REL_LAT - 1, 4'b0010);
        exp_held(REL_LAT, 4'b0000);
        tick(10);

        // Bounce on key 2: 2-cycle toggles, then a stable press
        for (int i = 1; i <= 12; i++) exp_held(i, 4'b0000);
        for (int i = 0; i < 6; i++) begin
            kif.key_raw[2] = (i % 2 == 0) ? 1'b0 : 1'b1;
            tick(2);
        end
        kif.key_raw[2] = 1'b0;
        exp_pulse(LAT, 4'b0100);
        exp_held(LAT - 1, 4'b0000);
        exp_held(LAT, 4'b0100);
        tick(12);
        kif.key_raw[2] = 1'b1;
        exp_held(REL_LAT, 4'b0000);
        tick(10);

        // Simultaneous press of keys 0 and 2: only key 0 pulses
        kif.key_raw[0] = 1'b0;
        kif.key_raw[2] = 1'b0;
        exp_pulse(LAT, 4'b0001);
        exp_held(LAT, 4'b0101);
        tick(12);
        kif.key_raw[0] = 1'b1;
        kif.key_raw[2] = 1'b1;
        exp_held(REL_LAT, 4'b0000);
        tick(10);

        // Release glitch on key 3: held stays, no second pulse
        kif.key_raw[3] = 1'b0;
        exp_pulse(LAT, 4'b1000);
        exp_held(LAT, 4'b1000);
        tick(12);
        for (int i = 1; i <= 10; i++) exp_held(i, 4'b1000);
        kif.key_raw[3] = 1'b1;
        tick(2);
        kif.key_raw[3] = 1'b0;
        tick(12);
        kif.key_raw[3] = 1'b1;
        exp_held(REL_LAT, 4'b0000);
        tick(10);

        // Reset while key 1 is in PRESS_WAIT (counter = 2), key 0 held
        kif.key_raw[0] = 1'b0;
        exp_pulse(LAT, 4'b0001);
        exp_held(LAT, 4'b0001);
        tick(12);
        kif.key_raw[1] = 1'b0;
        exp_held(3, 4'b0001);
        tick(4);
        reset = 1'b1;
        kif.key_raw[0] = 1'b1;
        tick(2);
        reset = 1'b0;
        exp_pulse(LAT, 4'b0010);
        exp_held(LAT - 1, 4'b0000);
        exp_held(LAT, 4'b0010);
        tick(12);
        kif.key_raw[1] = 1'b1;
        exp_held(REL_LAT, 4'b0000);
        tick(10);

        // Long hold on key 3: exactly one pulse
        kif.key_raw[3] = 1'b0;
        exp_pulse(LAT, 4'b1000);
        exp_held(LAT, 4'b1000);
        exp_held(999, 4'b1000);
        tick(1000);
        kif.key_raw[3] = 1'b1;
        exp_held(REL_LAT, 4'b0000);
        tick(10);

        done = 1'b1;
        for (int i = 0; i < 10 && !final_checked; i++) tick(1);
        if (!final_checked) begin
            $display("FAIL final_check: monitor did not drain the scoreboard");
            $fatal(1);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
